// File: rtl/prbs_burst_ctrl_pkg.sv
// Shared types and constants for the PRBS31 burst controller and its LFSR core.
package prbs_pkg;

  // Width of the burst length and of the ones counter.
  localparam int LEN_W = 16;
  // LFSR width; fixed at 31 for x^31 + x^28 + 1.
  localparam int LFSR_W = 31;
  // Second feedback tap: feedback = lfsr[TAP] ^ lfsr[LFSR_W-1].
  localparam int TAP = 27;
  // Value used whenever the requested seed would lock the LFSR at zero.
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 31'd1;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Map the all-zero seed onto DEFAULT_SEED so the LFSR can never stall.
  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] raw);
    logic [LFSR_W-1:0] eff;
    if (raw == {LFSR_W{1'b0}}) begin
      eff = DEFAULT_SEED;
    end else begin
      eff = raw;
    end
    return eff;
  endfunction

endpackage

// File: rtl/prbs_burst_ctrl_lfsr31_core.sv
// PRBS31 shift/feedback register. Load has priority over step; the output
// bit of the sequence is q[LFSR_W-1].
module lfsr31_core #(
  parameter int LFSR_W = prbs_pkg::LFSR_W,
  parameter int TAP    = prbs_pkg::TAP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] lfsr_r;

  // Shift register: reset to the default seed, load a new seed, or advance one step.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      lfsr_r <= prbs_pkg::DEFAULT_SEED;
    end else if (load) begin
      lfsr_r <= load_val;
    end else if (step) begin
      lfsr_r <= {lfsr_r[LFSR_W-2:0], lfsr_r[TAP] ^ lfsr_r[LFSR_W-1]};
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign q = lfsr_r;

endmodule

// File: rtl/prbs_burst_ctrl.sv
// Burst controller for the PRBS31 generator: byte-serial seed loading,
// start/pause/abort sequencing, bit metering and a ones counter.
// Note: rst_n keeps its historical name but is an active-high async reset.
module prbs_burst_ctrl #(
  parameter int LEN_W  = prbs_pkg::LEN_W,
  parameter int LFSR_W = prbs_pkg::LFSR_W,
  parameter int TAP    = prbs_pkg::TAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       seed_byte,
  input  logic             seed_we,
  input  logic [LEN_W-1:0] len,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             bit_out,
  output logic             bit_valid,
  output logic [LEN_W-1:0] ones_cnt
);

  import prbs_pkg::*;

  localparam logic [LEN_W-1:0] ONE_L  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] ZERO_L = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] SAT_L  = {LEN_W{1'b1}};

  state_t            state_r;
  state_t            state_s;
  // Only bits [30:0] of the 32-bit shift shadow ever reach the LFSR, so the
  // bit that would sit at position 31 is simply dropped on each shift.
  logic [LFSR_W-1:0] seed_sh_r;
  logic [LFSR_W-1:0] seed_eff_s;
  logic [LEN_W-1:0]  remaining_r;
  logic [LEN_W-1:0]  ones_cnt_r;
  logic              busy_r;
  logic              done_r;
  logic              accept_s;
  logic              seed_shift_s;
  logic              load_s;
  logic              step_s;
  logic [LFSR_W-1:0] lfsr_q_s;

  assign seed_eff_s = seed_fix(seed_sh_r);

  // Control decode: which datapath actions happen this cycle.
  always_comb begin
    accept_s     = 1'b0;
    seed_shift_s = 1'b0;
    load_s       = 1'b0;
    step_s       = 1'b0;
    if (state_r == IDLE) begin
      accept_s     = start;
      seed_shift_s = seed_we;
    end else if (state_r == LOAD) begin
      load_s = ~abort;
    end else if (state_r == RUN) begin
      step_s = ~pause & ~abort;
    end else begin
      step_s = 1'b0;
    end
  end

  // Next-state logic; abort beats both pause and completion.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          state_s = IDLE;
        end else if (remaining_r != ZERO_L) begin
          state_s = RUN;
        end else begin
          state_s = DONE;
        end
      end
      RUN: begin
        if (abort) begin
          state_s = IDLE;
        end else if (pause) begin
          state_s = RUN;
        end else if (remaining_r == ONE_L) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register plus busy/done, registered from the next state so they track state exactly.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
    end
  end

  // Seed shadow: byte-serial, MSB byte first, writable only while idle.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      seed_sh_r <= prbs_pkg::DEFAULT_SEED;
    end else if (seed_shift_s) begin
      seed_sh_r <= {seed_sh_r[LFSR_W-9:0], seed_byte};
    end else begin
      seed_sh_r <= seed_sh_r;
    end
  end

  // Remaining-bit counter: latched on start, decremented on each emitted bit.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      remaining_r <= ZERO_L;
    end else if (accept_s) begin
      remaining_r <= len;
    end else if (step_s) begin
      remaining_r <= remaining_r - ONE_L;
    end else begin
      remaining_r <= remaining_r;
    end
  end

  // Ones counter: cleared on start, counts emitted 1 bits, saturates; kept after abort.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ones_cnt_r <= ZERO_L;
    end else if (accept_s) begin
      ones_cnt_r <= ZERO_L;
    end else if (step_s && lfsr_q_s[LFSR_W-1] && (ones_cnt_r != SAT_L)) begin
      ones_cnt_r <= ones_cnt_r + ONE_L;
    end else begin
      ones_cnt_r <= ones_cnt_r;
    end
  end

  lfsr31_core #(
    .LFSR_W (LFSR_W),
    .TAP    (TAP)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .load_val (seed_eff_s),
    .step     (step_s),
    .q        (lfsr_q_s)
  );

  assign busy      = busy_r;
  assign done      = done_r;
  assign ones_cnt  = ones_cnt_r;
  // A bit is consumed exactly when the LFSR steps; the bit is forced low otherwise.
  assign bit_valid = step_s;
  assign bit_out   = step_s & lfsr_q_s[LFSR_W-1];

endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// Randomized self-checking bench for prbs_burst_ctrl. The reference stream is
// produced from the PRBS31 sequence recurrence b[k+31] = b[k] ^ b[k+3], with the
// first 31 bits read straight from the effective seed.
module tb_prbs_burst_ctrl;

  localparam int LEN_W = 16;

  logic             clk;
  logic             rst_n;
  logic [7:0]       seed_byte;
  logic             seed_we;
  logic [LEN_W-1:0] len;
  logic             start;
  logic             pause;
  logic             abort;
  logic             busy;
  logic             done;
  logic             bit_out;
  logic             bit_valid;
  logic [LEN_W-1:0] ones_cnt;

  int          checks;
  int          failures;
  logic [31:0] m_seed_sh;
  bit          stream [$];

  prbs_burst_ctrl #(
    .LEN_W  (LEN_W),
    .LFSR_W (31),
    .TAP    (27)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_byte (seed_byte),
    .seed_we   (seed_we),
    .len       (len),
    .start     (start),
    .pause     (pause),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .ones_cnt  (ones_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected bit sequence for the current model seed.
  task automatic build_stream(input int n);
    logic [30:0] s;
    s = m_seed_sh[30:0];
    if (s == 31'd0) s = 31'd1;
    stream.delete();
    for (int k = 0; k < n; k++) begin
      if (k < 31) stream.push_back(s[30-k]);
      else        stream.push_back(stream[k-31] ^ stream[k-28]);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input int exp_ones);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_valid"}, 32'(bit_valid), 32'd0);
    check_val({tag, "_bit"}, 32'(bit_out), 32'd0);
    check_val({tag, "_ones"}, 32'(ones_cnt), 32'(exp_ones));
  endtask

  // One burst, starting at negedge+1 with the DUT idle; returns at negedge+1 idle.
  task automatic run_burst(input logic [31:0] seed_word, input bit write_seed, input bit overlap,
                           input int blen, input int pause_pct, input int pause_at,
                           input int pause_len, input int abort_at, input int rst_at);
    int phase;   // 0 load, 1 run, 2 done, 3 finished
    int emitted;
    int ones;
    int cyc;
    int pcount;
    bit exp_valid;
    bit exp_bit;
    phase = 0; emitted = 0; ones = 0; cyc = 0; pcount = 0;
    if (write_seed) begin
      for (int i = 0; i < 4; i++) begin
        seed_we   = 1'b1;
        seed_byte = seed_word[31-8*i -: 8];
        m_seed_sh = {m_seed_sh[23:0], seed_byte};
        if (overlap && i == 3) begin
          start = 1'b1;
          len   = LEN_W'(blen);
        end
        @(negedge clk);
      end
    end
    if (!(write_seed && overlap)) begin
      seed_we = 1'b0;
      start   = 1'b1;
      len     = LEN_W'(blen);
      @(negedge clk);
    end
    seed_we = 1'b0;
    start   = 1'b0;
    build_stream(blen);
    while (phase != 3 && cyc < 8 * blen + 50) begin
      pause = 1'b0; abort = 1'b0; start = 1'b0; seed_we = 1'b0;
      if (pause_at >= 0) begin
        if (phase == 1 && emitted == pause_at && pcount < pause_len) begin
          pause = 1'b1;
          pcount++;
        end
      end else begin
        pause = ($urandom_range(0, 99) < pause_pct);
      end
      if (phase == 1 && emitted == abort_at) abort = 1'b1;
      if ($urandom_range(0, 9) == 0) begin
        start     = 1'b1;
        len       = LEN_W'($urandom_range(0, 200));
        seed_we   = 1'b1;
        seed_byte = 8'($urandom);
      end
      if (phase == 1 && emitted == rst_at) begin
        start = 1'b0; seed_we = 1'b0; pause = 1'b0; abort = 1'b0;
        rst_n = 1'b1;
        #1;
        check_idle_outputs("midrst", 0);
        @(negedge clk);
        #1;
        check_val("midrst_nodone", 32'(done), 32'd0);
        @(negedge clk);
        rst_n     = 1'b0;
        m_seed_sh = 32'h0000_0001;
        ones      = 0;
        phase     = 3;
      end else begin
        #1;
        exp_valid = (phase == 1) && !pause && !abort;
        exp_bit   = exp_valid ? stream[emitted] : 1'b0;
        check_val("busy", 32'(busy), 32'd1);
        check_val("done", 32'(done), 32'(phase == 2));
        check_val("bit_valid", 32'(bit_valid), 32'(exp_valid));
        check_val("bit_out", 32'(bit_out), 32'(exp_bit));
        check_val("ones_cnt", 32'(ones_cnt), 32'(ones));
        case (phase)
          0: phase = abort ? 3 : ((blen == 0) ? 2 : 1);
          1: begin
            if (abort) begin
              phase = 3;
            end else if (exp_valid) begin
              ones += int'(exp_bit);
              emitted++;
              if (emitted == blen) phase = 2;
            end
          end
          default: phase = 3;
        endcase
        @(negedge clk);
        cyc++;
      end
    end
    if (phase != 3) check_val("burst_bound", 32'(phase), 32'd3);
    pause = 1'b0; abort = 1'b0; start = 1'b0; seed_we = 1'b0;
    #1;
    check_idle_outputs("end", ones);
  endtask

  initial begin
    int blen;
    int ab;
    bit wr;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b1;
    seed_byte = 8'd0;
    seed_we   = 1'b0;
    len       = '0;
    start     = 1'b0;
    pause     = 1'b0;
    abort     = 1'b0;
    m_seed_sh = 32'h0000_0001;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_idle_outputs("reset", 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;

    // Seed 1: thirty zeros then a single one.
    run_burst(32'h0000_0001, 1'b1, 1'b0, 31, 0, -1, 0, -1, -1);
    check_val("seed1_ones", 32'(ones_cnt), 32'd1);
    // All-ones seed: eight ones.
    run_burst(32'h7FFF_FFFF, 1'b1, 1'b0, 8, 0, -1, 0, -1, -1);
    check_val("seedff_ones", 32'(ones_cnt), 32'd8);
    // All-zero seed behaves as seed 1.
    run_burst(32'h0000_0000, 1'b1, 1'b0, 31, 0, -1, 0, -1, -1);
    check_val("seed0_ones", 32'(ones_cnt), 32'd1);
    // Zero-length burst.
    run_burst(32'h0, 1'b0, 1'b0, 0, 0, -1, 0, -1, -1);
    check_val("len0_ones", 32'(ones_cnt), 32'd0);
    // Pause window at bit 10, abort at bit 20.
    run_burst(32'h0000_0001, 1'b1, 1'b0, 40, 0, 10, 5, 20, -1);
    check_val("abort_ones", 32'(ones_cnt), 32'd0);
    // Last seed byte written in the same cycle as start.
    run_burst($urandom, 1'b1, 1'b1, 64, 20, -1, 0, -1, -1);

    for (int r = 0; r < 6; r++) begin
      blen = $urandom_range(0, 120);
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, blen) : -1;
      wr   = ($urandom_range(0, 3) != 0);
      run_burst(($urandom_range(0, 4) == 0) ? 32'h0 : $urandom, wr,
                1'($urandom_range(0, 1)), blen, 25, -1, 0, ab, -1);
    end

    // Reset in the middle of a burst, then a burst that must use seed 1.
    run_burst(32'h7FFF_FFFF, 1'b1, 1'b0, 50, 0, -1, 0, -1, 12);
    run_burst(32'h0, 1'b0, 1'b0, 31, 0, -1, 0, -1, -1);
    check_val("postrst_ones", 32'(ones_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
